uart_dbg_responder: RTL and testbench
=====================================

// Module: uart_dbg_responder
// PURPOSE
//   Debug-link responder sitting behind the UART wrapper. It consumes host command bytes
//   from the RX side (rx_data/rx_data_rdy) and answers through the TX char FIFO
//   (write side: data/write_enable, backpressure: fifo full).
//   It controls MIPS pipeline run/halt/single-step and returns register-file and PC words,
//   MSB byte first.
// PARAMETERS
//   DATA_W        32     width of returned words; must be a multiple of 8
//   REG_AW        5      register index width (32 GPRs)
//   TIMEOUT_CYC   100000 idle cycles in WAIT_ARG before a partial command is discarded
// PORTS
//   clk           in   1       system clock; all logic on rising edge
//   rst           in   1       asynchronous, active-low reset
//   rx_data       in   8       received byte; valid only while rx_data_rdy=1
//   rx_data_rdy   in   1       one-cycle strobe per received byte
//   tx_fifo_full  in   1       TX char FIFO full
//   tx_data       out  8       byte to TX FIFO (registered)
//   tx_wr_en      out  1       TX FIFO push; only asserted while tx_fifo_full=0
//   dbg_run       out  1       1 = pipeline free-running clock enable
//   dbg_step      out  1       one-cycle pulse = advance pipeline one clock
//   dbg_reg_addr  out  REG_AW  register-file debug read index
//   dbg_reg_data  in   DATA_W  register-file contents at dbg_reg_addr (combinational)
//   dbg_pc        in   DATA_W  current PC
//   busy          out  1       1 whenever state != IDLE
//   rx_drop       out  1       one-cycle pulse: byte received while not accepting
// BEHAVIOUR
//   Reset: state=IDLE; tx_data=0, tx_wr_en=0, dbg_run=0, dbg_step=0, dbg_reg_addr=0,
//     busy=0, rx_drop=0; shift register and counters cleared. Reset mid-reply aborts it;
//     no further bytes are pushed.
//   Commands (ACK=0x06, NAK=0x15):
//     'R'(0x52): dbg_run<=1, reply ACK.   'H'(0x48): dbg_run<=0, reply ACK.
//     'S'(0x53): if dbg_run=0, dbg_step=1 for exactly one cycle, reply ACK;
//       else no pulse, reply NAK.
//     'P'(0x50): reply dbg_pc as DATA_W/8 bytes, MSB first.
//     'G'(0x47)+idx: idx<2^REG_AW -> reply dbg_reg_data[idx], MSB first; else NAK.
//     Any other byte in IDLE: reply NAK.
//   FSM: IDLE -> (rx 'G') WAIT_ARG -> (rx idx) LOAD -> SEND -> IDLE.
//     IDLE -> (other cmd) SEND. Every reply is loaded into a DATA_W shift register
//     plus a byte counter (1 for ACK/NAK). SEND: tx_wr_en=1 in each cycle with
//     tx_fifo_full=0. Each push shifts the next byte into tx_data and decrements
//     the counter. Pushing the last byte returns to IDLE.
//   Timing: command strobe at cycle N -> dbg_run/dbg_step change at N+1; first
//     tx_wr_en at N+1 if not full.
//     'G' idx strobe at M -> dbg_reg_addr=idx at M+1 (LOAD); dbg_reg_data sampled at
//     the end of M+1; first byte pushed at M+2. 'P' samples dbg_pc in the strobe cycle.
//   Backpressure: while tx_fifo_full=1, tx_wr_en=0 and tx_data holds. No byte is lost
//     or duplicated.
//   Bytes arriving in WAIT_ARG are taken as idx. Bytes arriving in LOAD/SEND are
//     discarded, with rx_drop=1 for that cycle and no state change.
//   WAIT_ARG timeout: counter cleared on entry. After TIMEOUT_CYC cycles with no strobe,
//     return to IDLE silently with no reply. A strobe in the same cycle as the timeout
//     is taken as idx.
//   dbg_reg_addr holds its last value outside LOAD.
// TESTING
//   1. After reset, rx 0x52 -> dbg_run=1 next cycle; exactly one push of 0x06.
//      rx 0x48 -> dbg_run=0; push 0x06.
//   2. Halted, rx 0x53 -> dbg_step high exactly 1 cycle, push 0x06.
//      Running, rx 0x53 -> no pulse, push 0x15.
//   3. Regfile[5]=0xDEADBEEF; rx 0x47,0x05 -> dbg_reg_addr=5;
//      pushes 0xDE,0xAD,0xBE,0xEF in order.
//   4. Same as 3 with tx_fifo_full toggling every 2 cycles -> same 4 bytes,
//      no wr_en while full.
//   5. rx 0x47,0x20 -> single 0x15. rx 0x47 then silence TIMEOUT_CYC -> IDLE, nothing
//      pushed. rx 0x99 -> 0x15.
//   6. rx 0x50 with pc=0x00400010, extra byte during SEND -> rx_drop pulse;
//      bytes 00,40,00,10. Assert rst mid-SEND -> all outputs 0, no further pushes.

Source files
------------

// File: rtl/uart_dbg_responder.sv
// rtl/uart_dbg_responder.sv - UART debug-link responder: run/halt/step control and PC/GPR readback
// Replies are staged in a byte-shift register and drained MSB byte first into the TX FIFO.
module uart_dbg_responder #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_rdy,
  input  logic              tx_fifo_full,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  output logic              dbg_run,
  output logic              dbg_step,
  output logic [REG_AW-1:0] dbg_reg_addr,
  input  logic [DATA_W-1:0] dbg_reg_data,
  input  logic [DATA_W-1:0] dbg_pc,
  output logic              busy,
  output logic              rx_drop
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_G = 8'h47;

  typedef enum logic [1:0] {IDLE, WAIT_ARG, LOAD, SEND} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              run_q, run_d;
  logic              step_q, step_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [7:0]        idx_hi;
  logic              push;

  // Any set bit above the register index width makes the index out of range.
  assign idx_hi = rx_data >> REG_AW;
  assign push   = (state_q == SEND) && !tx_fifo_full;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    run_d     = run_q;
    step_d    = 1'b0;
    addr_d    = addr_q;
    unique case (state_q)
      IDLE: begin
        if (rx_data_rdy) begin
          state_d   = SEND;
          cnt_d     = CNT_W'(1);
          tx_data_d = ACK;
          unique case (rx_data)
            CMD_R: run_d = 1'b1;
            CMD_H: run_d = 1'b0;
            CMD_S: begin
              if (run_q) tx_data_d = NAK;
              else       step_d    = 1'b1;
            end
            CMD_P: begin
              tx_data_d = dbg_pc[DATA_W-1 -: 8];
              shreg_d   = dbg_pc << 8;
              cnt_d     = CNT_W'(NBYTES);
            end
            CMD_G: begin
              state_d = WAIT_ARG;
              tmo_d   = '0;
            end
            default: tx_data_d = NAK;
          endcase
        end
      end
      WAIT_ARG: begin
        if (rx_data_rdy) begin
          if (idx_hi == 8'd0) begin
            addr_d  = REG_AW'(rx_data);
            state_d = LOAD;
          end else begin
            tx_data_d = NAK;
            cnt_d     = CNT_W'(1);
            state_d   = SEND;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      LOAD: begin
        tx_data_d = dbg_reg_data[DATA_W-1 -: 8];
        shreg_d   = dbg_reg_data << 8;
        cnt_d     = CNT_W'(NBYTES);
        state_d   = SEND;
      end
      SEND: begin
        if (push) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end else begin
            tx_data_d = shreg_q[DATA_W-1 -: 8];
            shreg_d   = shreg_q << 8;
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      tx_data_q <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      run_q     <= run_d;
      step_q    <= step_d;
      addr_q    <= addr_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_wr_en     = push;
  assign dbg_run      = run_q;
  assign dbg_step     = step_q;
  assign dbg_reg_addr = addr_q;
  assign busy         = (state_q != IDLE);
  // Bytes are only refused while a reply is being assembled or drained.
  assign rx_drop      = rx_data_rdy && ((state_q == LOAD) || (state_q == SEND));

endmodule

// File: tb/tb_uart_dbg_responder.sv
// tb/tb_uart_dbg_responder.sv - self-checking bench for uart_dbg_responder
module tb_uart_dbg_responder;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_data_rdy = 1'b0;
  logic              tx_fifo_full = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_wr_en;
  logic              dbg_run;
  logic              dbg_step;
  logic [REG_AW-1:0] dbg_reg_addr;
  logic [DATA_W-1:0] dbg_reg_data;
  logic [DATA_W-1:0] dbg_pc = '0;
  logic              busy;
  logic              rx_drop;

  logic [DATA_W-1:0] regs [32];
  assign dbg_reg_data = regs[dbg_reg_addr];

  uart_dbg_responder #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .tx_fifo_full(tx_fifo_full), .tx_data(tx_data), .tx_wr_en(tx_wr_en),
    .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_data(dbg_reg_data), .dbg_pc(dbg_pc), .busy(busy), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int step_seen = 0;
  int drop_seen = 0;
  int wr_while_full = 0;
  int bp_mode = 0;
  int cyc = 0;

  // FIFO full pattern: 0 never, 1 toggles every 2 cycles, 2 always, 3 random.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    case (bp_mode)
      0:       tx_fifo_full = 1'b0;
      1:       tx_fifo_full = cyc[1];
      2:       tx_fifo_full = 1'b1;
      default: tx_fifo_full = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (tx_wr_en) begin
        if (tx_fifo_full) wr_while_full = wr_while_full + 1;
        got_q.push_back(tx_data);
      end
      if (dbg_step) step_seen = step_seen + 1;
      if (rx_drop)  drop_seen = drop_seen + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
    end
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic has_arg, input logic [7:0] a);
    got_q.delete();
    step_seen = 0;
    send(c);
    if (has_arg) send(a);
    wait_idle();
  endtask

  task automatic compare_bytes(input string tag);
    check($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic        has_arg;
    logic [7:0]  arg;
    int          bp;
    logic [63:0] exp_bytes;
    int          nbytes;
    logic        exp_run;
    int          exp_steps;
  } vec_t;

  vec_t vecs [13];
  logic model_run;

  initial begin
    vecs[0]  = '{8'h52, 1'b0, 8'h00, 0, 64'h06,       1, 1'b1, 0};
    vecs[1]  = '{8'h48, 1'b0, 8'h00, 0, 64'h06,       1, 1'b0, 0};
    vecs[2]  = '{8'h53, 1'b0, 8'h00, 0, 64'h06,       1, 1'b0, 1};
    vecs[3]  = '{8'h52, 1'b0, 8'h00, 0, 64'h06,       1, 1'b1, 0};
    vecs[4]  = '{8'h53, 1'b0, 8'h00, 0, 64'h15,       1, 1'b1, 0};
    vecs[5]  = '{8'h48, 1'b0, 8'h00, 1, 64'h06,       1, 1'b0, 0};
    vecs[6]  = '{8'h50, 1'b0, 8'h00, 0, 64'h00400010, 4, 1'b0, 0};
    vecs[7]  = '{8'h47, 1'b1, 8'h05, 0, 64'hDEADBEEF, 4, 1'b0, 0};
    vecs[8]  = '{8'h47, 1'b1, 8'h05, 1, 64'hDEADBEEF, 4, 1'b0, 0};
    vecs[9]  = '{8'h47, 1'b1, 8'h20, 0, 64'h15,       1, 1'b0, 0};
    vecs[10] = '{8'h99, 1'b0, 8'h00, 0, 64'h15,       1, 1'b0, 0};
    vecs[11] = '{8'h53, 1'b0, 8'h00, 1, 64'h06,       1, 1'b0, 1};
    vecs[12] = '{8'h47, 1'b1, 8'h1F, 3, 64'hCAFEF00D, 4, 1'b0, 0};

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5]  = 32'hDEADBEEF;
    regs[31] = 32'hCAFEF00D;
    dbg_pc   = 32'h00400010;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({tx_data, tx_wr_en, dbg_run, dbg_step, dbg_reg_addr, busy, rx_drop}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int v = 0; v < 13; v++) begin
      bp_mode = vecs[v].bp;
      do_cmd(vecs[v].cmd, vecs[v].has_arg, vecs[v].arg);
      exp_q.delete();
      for (int b = vecs[v].nbytes - 1; b >= 0; b--) exp_q.push_back(vecs[v].exp_bytes[8*b +: 8]);
      compare_bytes($sformatf("vec%0d", v));
      check($sformatf("vec%0d_run", v), 64'(dbg_run), 64'(vecs[v].exp_run));
      check($sformatf("vec%0d_steps", v), 64'(step_seen), 64'(vecs[v].exp_steps));
    end
    bp_mode = 0;

    // Command-to-effect latency for 'R'.
    @(posedge clk); #1;
    rx_data = 8'h52;
    rx_data_rdy = 1'b1;
    @(negedge clk);
    check("r_timing_run_before", 64'(dbg_run), 64'd0);
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
    @(negedge clk);
    check("r_timing_run_after", 64'(dbg_run), 64'd1);
    check("r_timing_wr_en", 64'(tx_wr_en), 64'd1);
    check("r_timing_data", 64'(tx_data), 64'h06);
    wait_idle();
    model_run = 1'b1;

    // 'G' index latency: address in LOAD, first push one cycle later.
    regs[9] = 32'h12345678;
    got_q.delete();
    send(8'h47);
    rx_data = 8'h09;
    rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
    @(negedge clk);
    check("g_timing_addr", 64'(dbg_reg_addr), 64'd9);
    check("g_timing_load_no_wr", 64'(tx_wr_en), 64'd0);
    @(negedge clk);
    check("g_timing_first_wr", 64'(tx_wr_en), 64'd1);
    check("g_timing_first_byte", 64'(tx_data), 64'h12);
    wait_idle();
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    compare_bytes("g_timing");

    // WAIT_ARG timeout returns silently.
    got_q.delete();
    send(8'h47);
    repeat (TMO / 2) @(posedge clk);
    #1;
    check("timeout_still_waiting", 64'(busy), 64'd1);
    repeat (TMO) @(posedge clk);
    #1;
    check("timeout_back_idle", 64'(busy), 64'd0);
    check("timeout_no_push", 64'(got_q.size()), 64'd0);
    do_cmd(8'h99, 1'b0, 8'h00);
    exp_q = '{8'h15};
    compare_bytes("after_timeout");

    // Byte arriving during a stalled SEND is dropped.
    got_q.delete();
    drop_seen = 0;
    bp_mode = 2;
    send(8'h50);
    @(posedge clk); #1;
    rx_data = 8'hAA;
    rx_data_rdy = 1'b1;
    @(negedge clk);
    check("drop_pulse", 64'(rx_drop), 64'd1);
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
    bp_mode = 0;
    wait_idle();
    exp_q = '{8'h00, 8'h40, 8'h00, 8'h10};
    compare_bytes("drop_reply");
    check("drop_count", 64'(drop_seen), 64'd1);

    // Randomized commands against the reply model.
    for (int it = 0; it < 80; it++) begin
      logic [7:0] c, a;
      int k;
      k = $urandom_range(0, 5);
      a = 8'($urandom_range(0, 40));
      case (k)
        0: c = 8'h52;
        1: c = 8'h48;
        2: c = 8'h53;
        3: c = 8'h50;
        4: c = 8'h47;
        default: begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'h47) c = 8'h00;
        end
      endcase
      dbg_pc = $urandom;
      bp_mode = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 3);
      exp_q.delete();
      case (c)
        8'h52: begin model_run = 1'b1; exp_q.push_back(8'h06); end
        8'h48: begin model_run = 1'b0; exp_q.push_back(8'h06); end
        8'h53: exp_q.push_back(model_run ? 8'h15 : 8'h06);
        8'h50: for (int b = DATA_W/8 - 1; b >= 0; b--) exp_q.push_back(dbg_pc[8*b +: 8]);
        8'h47: begin
          if (a < 32) for (int b = DATA_W/8 - 1; b >= 0; b--) exp_q.push_back(regs[a][8*b +: 8]);
          else exp_q.push_back(8'h15);
        end
        default: exp_q.push_back(8'h15);
      endcase
      do_cmd(c, (c == 8'h47), a);
      compare_bytes($sformatf("rnd%0d_cmd%0h", it, c));
      check($sformatf("rnd%0d_run", it), 64'(dbg_run), 64'(model_run));
      check($sformatf("rnd%0d_steps", it), 64'(step_seen),
            64'((c == 8'h53 && !model_run) ? 1 : 0));
    end
    bp_mode = 0;

    // Reset in the middle of a reply aborts it.
    do_cmd(8'h52, 1'b0, 8'h00);
    got_q.delete();
    bp_mode = 1;
    dbg_pc = 32'hA1B2C3D4;
    send(8'h50);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_outputs", 64'({tx_data, tx_wr_en, dbg_run, dbg_step, dbg_reg_addr, busy, rx_drop}), 64'd0);
    begin
      int n_before;
      n_before = got_q.size();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      bp_mode = 0;
      repeat (12) @(posedge clk);
      #1;
      check("midreset_no_more_push", 64'(got_q.size()), 64'(n_before));
      check("midreset_idle", 64'(busy), 64'd0);
    end

    check("no_wr_while_full", 64'(wr_while_full), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
